// File: rtl/qif_neuron_array_if.sv
// Bus bundle for qif_neuron_array: update enable, synaptic currents, monitor
// select and the spike/monitor outputs.
interface qif_neuron_array_if #(
  parameter int WIDTH  = 8,
  parameter int N_NEUR = 4
);
  localparam int ID_W = $clog2(N_NEUR);

  logic                    en;
  logic [N_NEUR*WIDTH-1:0] i_syn;
  logic [ID_W-1:0]         mon_sel;
  logic [WIDTH-1:0]        v_mon;
  logic                    spike_vld;
  logic [ID_W-1:0]         spike_id;
  logic [N_NEUR-1:0]       spike_vec;
  logic                    round_done;

  modport master (
    output en, i_syn, mon_sel,
    input  v_mon, spike_vld, spike_id, spike_vec, round_done
  );

  modport slave (
    input  en, i_syn, mon_sel,
    output v_mon, spike_vld, spike_id, spike_vec, round_done
  );
endinterface

// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons sharing one update path.
// Optional macro QIF_REFRAC_EN adds per-neuron refractory counters.
module qif_neuron_array #(
  parameter int               WIDTH   = 8,
  parameter int               N_NEUR  = 4,
  parameter logic [WIDTH-1:0] V_TH    = 8'd240,
  parameter logic [WIDTH-1:0] V_RESET = 8'd0,
  parameter int               REFRAC  = 3,
  parameter int               SHIFT   = 8
) (
  input logic               clk,
  input logic               rst_n,
  qif_neuron_array_if.slave bus
);
  localparam int ID_W  = $clog2(N_NEUR);
  localparam int SUM_W = 2*WIDTH + 2;
  localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_NEUR-1);

  function automatic logic [WIDTH-1:0] f_sat(input logic [SUM_W-1:0] s);
    return (s > SAT_MAX) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0]  r_v [N_NEUR];
  logic [ID_W-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_v_mon;
  logic              r_spike_vld;
  logic [ID_W-1:0]   r_spike_id;
  logic [N_NEUR-1:0] r_spike_vec;
  logic              r_round_done;

  logic [WIDTH-1:0]  w_v;
  logic [WIDTH-1:0]  w_i;
  logic [SUM_W-1:0]  w_vw;
  logic [SUM_W-1:0]  w_sq;
  logic [SUM_W-1:0]  w_sum;
  logic [WIDTH-1:0]  w_vnext;
  logic              w_hold;
  logic              w_fire;
  logic [WIDTH-1:0]  w_vupd;

  // Shared update datapath operating on the neuron selected by r_ptr
  always_comb begin
    w_v     = r_v[r_ptr];
    w_i     = bus.i_syn[r_ptr*WIDTH +: WIDTH];
    w_vw    = SUM_W'(w_v);
    w_sq    = w_vw * w_vw;
    w_sum   = w_vw + (w_sq >> SHIFT) + SUM_W'(w_i);
    w_vnext = f_sat(w_sum);
    w_fire  = !w_hold && (w_vnext >= V_TH);
    w_vupd  = (w_hold || w_fire) ? V_RESET : w_vnext;
  end

`ifdef QIF_REFRAC_EN
  localparam int REF_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  logic [REF_W-1:0] r_ref [N_NEUR];

  assign w_hold = (r_ref[r_ptr] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEUR; k++) r_ref[k] <= '0;
    end else if (bus.en) begin
      if (w_hold)      r_ref[r_ptr] <= r_ref[r_ptr] - 1'b1;
      else if (w_fire) r_ref[r_ptr] <= REF_W'(REFRAC);
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  // Membrane, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEUR; k++) r_v[k] <= V_RESET;
      r_ptr        <= '0;
      r_v_mon      <= '0;
      r_spike_vld  <= 1'b0;
      r_spike_id   <= '0;
      r_spike_vec  <= '0;
      r_round_done <= 1'b0;
    end else begin
      r_v_mon <= r_v[bus.mon_sel];
      if (bus.en) begin
        r_v[r_ptr]         <= w_vupd;
        r_ptr              <= r_ptr + 1'b1;
        r_spike_vld        <= w_fire;
        r_spike_vec[r_ptr] <= w_fire;
        r_round_done       <= (r_ptr == LAST_ID);
        if (w_fire) r_spike_id <= r_ptr;
      end else begin
        r_spike_vld  <= 1'b0;
        r_round_done <= 1'b0;
      end
    end
  end

  assign bus.v_mon      = r_v_mon;
  assign bus.spike_vld  = r_spike_vld;
  assign bus.spike_id   = r_spike_id;
  assign bus.spike_vec  = r_spike_vec;
  assign bus.round_done = r_round_done;
endmodule

// File: doc/qif_neuron_array.md
QIF_NEURON_ARRAY -- requirements
Module: qif_neuron_array

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH 8 membrane/input bit width; N_NEUR 4 neuron count (2..16, power of two); V_TH 8'd240 spike threshold; V_RESET 8'd0 post-spike potential; REFRAC 3 refractory length in neuron updates; SHIFT 8 quadratic-term right shift.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  advance one neuron update this cycle.
REQ-005 i_syn  input  N_NEUR*WIDTH  synaptic current; neuron k at bits [k*WIDTH +: WIDTH], unsigned.
REQ-006 mon_sel  input  log2(N_NEUR)  neuron index driven on v_mon.
REQ-007 v_mon  output  WIDTH  registered membrane of neuron mon_sel.
REQ-008 spike_vld  output  1  one-cycle pulse: the neuron just updated fired.
REQ-009 spike_id  output  log2(N_NEUR)  index of the firing neuron, valid with spike_vld.
REQ-010 spike_vec  output  N_NEUR  bit k = last update outcome of neuron k (1 = fired).
REQ-011 round_done  output  1  one-cycle pulse when neuron N_NEUR-1 has been updated.

Function
REQ-012 The block SHALL time-multiplex one shared update datapath over N_NEUR membrane registers via pointer ptr.
REQ-013 On a cycle with en=1 the block SHALL update neuron ptr, then ptr SHALL increment, wrapping N_NEUR-1 -> 0; en=0 SHALL freeze all state and deassert pulses.
REQ-014 Update SHALL compute, at WIDTH*2+2 bits, sum = V + ((V*V) >> SHIFT) + I, I = i_syn slice of neuron ptr; V_next = min(sum, 2^WIDTH-1) (saturating, no wrap).
REQ-015 If V_next >= V_TH the neuron SHALL fire: V <= V_RESET, refractory counter <= REFRAC, spike_vld=1, spike_id=ptr, spike_vec[ptr]=1; otherwise V <= V_next, spike_vec[ptr]=0.
REQ-016 A neuron with nonzero refractory counter SHALL hold V = V_RESET, ignore I, decrement the counter by 1, and not fire.
REQ-017 spike_vld, spike_id, spike_vec, round_done SHALL be registered, asserting in the cycle after the en=1 edge that performed the update (latency 1).
REQ-018 round_done SHALL assert iff the update just performed was on neuron N_NEUR-1.
REQ-019 v_mon SHALL equal the registered membrane of mon_sel one cycle after mon_sel is applied; if mon_sel equals the neuron updated on the same edge, v_mon SHALL show the post-update value one cycle later.
REQ-020 i_syn SHALL be sampled only for the neuron being updated; other slices have no effect that cycle.

Reset
REQ-021 rst_n low SHALL immediately clear: all membranes to V_RESET, refractory counters 0, ptr 0, v_mon 0, spike_vld 0, spike_id 0, spike_vec 0, round_done 0.
REQ-022 Reset asserted mid-round SHALL discard the partial round; the first update after release SHALL be neuron 0.

Configuration
REQ-023 Macro QIF_REFRAC_EN: defined -> refractory counters and REQ-016 behaviour present; undefined -> no counters, a fired neuron resumes integrating from V_RESET at its next update, REFRAC ignored.

Verification
REQ-024 Reset, en=1, all i_syn=0 -> all V stay 0, no spike_vld, round_done every 4th cycle.
REQ-025 Neuron 0 V=0, i_syn[0]=100 -> V: 100, 239 (100+39+100), then fires: spike_vld=1, spike_id=0, V=0.
REQ-026 i_syn[2]=255 constant -> sum saturates/crosses V_TH on first update, spike_id=2; with QIF_REFRAC_EN next 3 updates of neuron 2 hold V=0, fire again on the 4th later update.
REQ-027 Same stimulus without QIF_REFRAC_EN -> neuron 2 fires on every update.
REQ-028 en toggled 1,0,0,1 -> ptr advances exactly twice; no pulses during en=0 cycles.
REQ-029 rst_n pulsed low while ptr=2 with V nonzero -> outputs clear asynchronously; next update targets neuron 0 from V=0.
